instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 96 +++++++++
 tb/tb_instr_encoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: turns a compact instruction description into an RV32I word
// and presents it, with its byte address, on a one-deep registered output.
//
// Ports:
//   clk, reset                 sole clock; synchronous active-high reset
//   in_valid / in_ready        request handshake
//   op_class, funct3, alt      0=R 1=I-ALU 2=LW 3=SW 4=BEQ (5-7 illegal)
//   rd, rs1, rs2, imm          register indices, 13-bit signed immediate
//   out_valid / out_ready      output handshake
//   out_instr, out_addr        encoded word and its byte address
//   err                        one-cycle pulse after an illegal request is consumed
//   count                      words emitted since reset (wraps)
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op_class,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [15:0] count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] enc;
  logic [6:0]  funct7;
  logic        illegal, acc, legal_acc, out_hs;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign out_hs    = out_valid && out_ready;
  assign acc       = in_valid && in_ready;
  assign funct7    = alt ? 7'b0100000 : 7'b0000000;
  // BEQ targets must be halfword aligned, so an odd offset is rejected.
  assign illegal   = (op_class >= 3'd5) || ((op_class == 3'd4) && imm[0]);
  assign legal_acc = acc && !illegal;

  always_comb begin
    enc = 32'h0;
    case (op_class)
      3'd0: enc = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      3'd1: begin
        // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
        if (funct3 == 3'b001 || funct3 == 3'b101)
          enc = {funct7, imm[4:0], rs1, funct3, rd, 7'b0010011};
        else
          enc = {imm[11:0], rs1, funct3, rd, 7'b0010011};
      end
      3'd2: enc = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      3'd3: enc = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      3'd4: enc = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      default: enc = 32'h0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (legal_acc) state_nxt = FULL;
      FULL:  if (out_hs) state_nxt = legal_acc ? FULL : EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      out_instr <= 32'h0;
      out_addr  <= BASE_ADDR;
      count     <= 16'h0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= acc && illegal;
      if (legal_acc) out_instr <= enc;
      if (out_hs) begin
        out_addr <= out_addr + 32'd4;
        count    <= count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed encodings, handshake,
// backpressure, illegal requests and mid-transfer reset.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, alt, out_valid, out_ready, err;
  logic [2:0]  op_class, funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [12:0] imm;
  logic [31:0] out_instr, out_addr;
  logic [15:0] count;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .funct3(funct3), .alt(alt), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [2:0] f3, input logic a,
                     input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [12:0] im);
    in_valid = 1'b1; op_class = op; funct3 = f3; alt = a;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_class = 3'd0; funct3 = 3'd0; alt = 1'b0;
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 13'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    chk("rst_addr", out_addr, BASE);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // R-type add x3,x1,x2 held until drained
    req(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
    tick();
    in_valid = 1'b0;
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_instr", out_instr, 32'h002081B3);
    chk("add_addr", out_addr, BASE);
    chk("add_count0", {16'd0, count}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("add_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("add_count1", {16'd0, count}, 32'd1);
    chk("add_addr_next", out_addr, BASE + 32'd4);

    // srai then lw back-to-back, one word per cycle
    req(3'd1, 3'd5, 1'b1, 5'd4, 5'd4, 5'd0, 13'd2);
    tick();
    chk("srai_instr", out_instr, 32'h40225213);
    chk("srai_addr", out_addr, BASE + 32'd4);
    chk("lw_ready", {31'd0, in_ready}, 32'd1);
    req(3'd2, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8);
    tick();
    chk("lw_valid", {31'd0, out_valid}, 32'd1);
    chk("lw_instr", out_instr, 32'h00812283);
    chk("lw_addr", out_addr, BASE + 32'd8);
    chk("lw_count", {16'd0, count}, 32'd2);

    // sw then beq -8
    req(3'd3, 3'd0, 1'b0, 5'd0, 5'd2, 5'd6, 13'd12);
    tick();
    chk("sw_instr", out_instr, 32'h00612623);
    chk("sw_addr", out_addr, BASE + 32'd12);
    req(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FF8);
    tick();
    in_valid = 1'b0;
    chk("beq_instr", out_instr, 32'hFE208CE3);
    chk("beq_addr", out_addr, BASE + 32'd16);
    tick();
    chk("beq_count", {16'd0, count}, 32'd5);
    chk("beq_drain_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: word A held 5 cycles while B waits
    out_ready = 1'b0;
    req(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
    tick();
    req(3'd2, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_instr", out_instr, 32'h002081B3);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    chk("bp_addr", out_addr, BASE + 32'd20);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_b_instr", out_instr, 32'h00812283);
    chk("bp_b_addr", out_addr, BASE + 32'd24);
    chk("bp_count_a", {16'd0, count}, 32'd6);
    tick();
    chk("bp_count_b", {16'd0, count}, 32'd7);
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Illegal op_class
    req(3'd6, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 13'd0);
    tick();
    in_valid = 1'b0;
    chk("ill_op_err", {31'd0, err}, 32'd1);
    chk("ill_op_valid", {31'd0, out_valid}, 32'd0);
    chk("ill_op_count", {16'd0, count}, 32'd7);
    tick();
    chk("ill_op_err_pulse", {31'd0, err}, 32'd0);

    // Odd BEQ offset
    req(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'h0003);
    tick();
    in_valid = 1'b0;
    chk("ill_beq_err", {31'd0, err}, 32'd1);
    chk("ill_beq_valid", {31'd0, out_valid}, 32'd0);
    chk("ill_beq_addr", out_addr, BASE + 32'd28);
    tick();
    chk("ill_beq_err_pulse", {31'd0, err}, 32'd0);

    // Illegal accept alongside an output handshake leaves the encoder empty
    req(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
    tick();
    req(3'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 13'd0);
    tick();
    in_valid = 1'b0;
    chk("ill_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("ill_hs_err", {31'd0, err}, 32'd1);
    chk("ill_hs_count", {16'd0, count}, 32'd8);
    chk("ill_hs_addr", out_addr, BASE + 32'd32);

    // Reset while full and stalled
    out_ready = 1'b0;
    req(3'd3, 3'd0, 1'b0, 5'd0, 5'd2, 5'd6, 13'd12);
    tick();
    in_valid = 1'b0;
    chk("mid_full", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_count", {16'd0, count}, 32'd0);
    chk("mid_addr", out_addr, BASE);
    chk("mid_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_instr", out_instr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
